// File: rtl/counter_pkg.sv
// Shared types and constants for the display counter sequencer.
// Contents: seq_state_t FSM encoding and button bit positions in btn_level_i.
// No logic; imported by counter_sequencer and its bench.
package counter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      HOLD  = 2'd3
   } seq_state_t;

   localparam int unsigned BTN_RUN  = 0;
   localparam int unsigned BTN_UP   = 1;
   localparam int unsigned BTN_DOWN = 2;
   localparam int unsigned BTN_LOAD = 3;

endpackage

// File: rtl/counter_sequencer_rise_edge_detect.sv
// Purpose: one-cycle rising-edge events from N level inputs (combinational from the history register).
// Ports: i_clk, i_rst (async, active-high), i_level[N] in; o_event[N] out.
// History resets to RST_HIST so a level already high at reset release yields no event until re-pressed.
module rise_edge_detect #(
   parameter int                N        = 4,
   parameter logic [N-1:0]      RST_HIST = '1
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic [N-1:0]  i_level,
   output logic [N-1:0]  o_event
);

   logic [N-1:0] r_hist;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_hist <= RST_HIST;
      end else begin
         r_hist <= i_level;
      end
   end

   assign o_event = i_level & ~r_hist;

endmodule

// File: rtl/counter_sequencer.sv
// Purpose: run/pause/direction/load FSM owning the 8-bit up/down display count register.
// Ports: CLOCK_50_I, RESET_I (async active-high), btn_level_i[4], tick_i, wrap_en_i, load_value_i in;
//        count_o, dir_down_o, state_o, running_o, bound_o out. Button effects land one cycle after the press is sampled.
module counter_sequencer
   import counter_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int MAX_COUNT = 255
) (
   input  logic              CLOCK_50_I,
   input  logic              RESET_I,
   input  logic [3:0]        btn_level_i,
   input  logic              tick_i,
   input  logic              wrap_en_i,
   input  logic [WIDTH-1:0]  load_value_i,
   output logic [WIDTH-1:0]  count_o,
   output logic              dir_down_o,
   output logic [1:0]        state_o,
   output logic              running_o,
   output logic              bound_o
);

   localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_COUNT);

   seq_state_t        r_state;
   logic [WIDTH-1:0]  r_count;
   logic              r_dir_down;
   logic              r_bound;

   logic [3:0]        w_ev;
   seq_state_t        w_state_nxt;
   logic [WIDTH-1:0]  w_count_nxt;
   logic              w_dir_nxt;
   logic              w_bound_nxt;
   logic              w_hold_release;

   rise_edge_detect #(
      .N        (4),
      .RST_HIST (4'hF)
   ) u_edge (
      .i_clk   (CLOCK_50_I),
      .i_rst   (RESET_I),
      .i_level (btn_level_i),
      .o_event (w_ev)
   );

   // Leaving HOLD only makes sense if the registered direction moves off the held bound.
   assign w_hold_release = ((r_count == MAX_C) && r_dir_down) ||
                           ((r_count == '0) && !r_dir_down);

   always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_count;
      w_dir_nxt   = r_dir_down;
      w_bound_nxt = 1'b0;

      // Simultaneous up and down presses cancel out.
      if (w_ev[BTN_UP] && !w_ev[BTN_DOWN]) begin
         w_dir_nxt = 1'b0;
      end else if (w_ev[BTN_DOWN] && !w_ev[BTN_UP]) begin
         w_dir_nxt = 1'b1;
      end

      if (w_ev[BTN_LOAD]) begin
         // Load masks run/pause and tick for this cycle.
         w_count_nxt = (load_value_i > MAX_C) ? MAX_C : load_value_i;
         w_state_nxt = PAUSE;
      end else begin
         // Step uses the direction registered at the start of the cycle.
         if ((r_state == RUN) && tick_i) begin
            if (!r_dir_down) begin
               if (r_count < MAX_C) begin
                  w_count_nxt = r_count + 1'b1;
               end else begin
                  w_bound_nxt = 1'b1;
                  if (wrap_en_i) begin
                     w_count_nxt = '0;
                  end else begin
                     w_state_nxt = HOLD;
                  end
               end
            end else begin
               if (r_count != '0) begin
                  w_count_nxt = r_count - 1'b1;
               end else begin
                  w_bound_nxt = 1'b1;
                  if (wrap_en_i) begin
                     w_count_nxt = MAX_C;
                  end else begin
                     w_state_nxt = HOLD;
                  end
               end
            end
         end

         // A run/pause press decides the state even when a step happened this cycle.
         if (w_ev[BTN_RUN]) begin
            case (r_state)
               IDLE:    w_state_nxt = RUN;
               RUN:     w_state_nxt = PAUSE;
               PAUSE:   w_state_nxt = RUN;
               HOLD:    w_state_nxt = w_hold_release ? RUN : HOLD;
               default: w_state_nxt = IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge CLOCK_50_I or posedge RESET_I) begin
      if (RESET_I) begin
         r_state    <= IDLE;
         r_count    <= '0;
         r_dir_down <= 1'b0;
         r_bound    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_count    <= w_count_nxt;
         r_dir_down <= w_dir_nxt;
         r_bound    <= w_bound_nxt;
      end
   end

   assign count_o    = r_count;
   assign dir_down_o = r_dir_down;
   assign state_o    = r_state;
   assign running_o  = (r_state == RUN);
   assign bound_o    = r_bound;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench: the driver pushes the hand-computed post-edge output snapshot for each cycle,
// a monitor pops and compares one snapshot per cycle on the falling edge.
// Instance u_dut uses MAX_COUNT=255, u_dut99 uses MAX_COUNT=99; each snapshot names which one it checks.
module tb_counter_sequencer;
   import counter_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] btn = 4'b0001;
   logic       tick = 1'b0;
   logic       wrap = 1'b0;
   logic [7:0] lv = 8'd0;

   logic [7:0] cnt_a, cnt_b;
   logic       dir_a, dir_b, run_a, run_b, bnd_a, bnd_b;
   logic [1:0] st_a, st_b;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int         sel;
      string      name;
      logic [7:0] cnt;
      logic       dir;
      logic [1:0] st;
      logic       bnd;
   } exp_t;

   exp_t q[$];

   always #10 clk = ~clk;

   counter_sequencer #(.WIDTH(8), .MAX_COUNT(255)) u_dut (
      .CLOCK_50_I   (clk),
      .RESET_I      (rst),
      .btn_level_i  (btn),
      .tick_i       (tick),
      .wrap_en_i    (wrap),
      .load_value_i (lv),
      .count_o      (cnt_a),
      .dir_down_o   (dir_a),
      .state_o      (st_a),
      .running_o    (run_a),
      .bound_o      (bnd_a)
   );

   counter_sequencer #(.WIDTH(8), .MAX_COUNT(99)) u_dut99 (
      .CLOCK_50_I   (clk),
      .RESET_I      (rst),
      .btn_level_i  (btn),
      .tick_i       (tick),
      .wrap_en_i    (wrap),
      .load_value_i (lv),
      .count_o      (cnt_b),
      .dir_down_o   (dir_b),
      .state_o      (st_b),
      .running_o    (run_b),
      .bound_o      (bnd_b)
   );

   task automatic check(input exp_t e);
      logic [7:0] c;
      logic       d, r, b;
      logic [1:0] s;
      logic       er;
      if (e.sel == 0) begin
         c = cnt_a; d = dir_a; s = st_a; r = run_a; b = bnd_a;
      end else begin
         c = cnt_b; d = dir_b; s = st_b; r = run_b; b = bnd_b;
      end
      er = (e.st == 2'd1);
      total++;
      if (c !== e.cnt || d !== e.dir || s !== e.st || r !== er || b !== e.bnd) begin
         bad++;
         $display("FAIL %s: got cnt=%0d dir=%0b st=%0d run=%0b bnd=%0b, want cnt=%0d dir=%0b st=%0d run=%0b bnd=%0b",
                  e.name, c, d, s, r, b, e.cnt, e.dir, e.st, er, e.bnd);
      end
   endtask

   // Monitor: one snapshot per clock, sampled mid-low-phase after the rising edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            check(e);
         end
      end
   end

   // Drive one cycle of inputs and queue the expected outputs after the next rising edge.
   task automatic cyc(input logic r, input logic w, input logic [3:0] b, input logic t,
                      input logic [7:0] v, input int sel, input string nm,
                      input logic [7:0] c, input logic d, input logic [1:0] s, input logic bn);
      exp_t e;
      @(negedge clk);
      #1;
      rst = r; wrap = w; btn = b; tick = t; lv = v;
      e.sel = sel; e.name = nm; e.cnt = c; e.dir = d; e.st = s; e.bnd = bn;
      q.push_back(e);
   endtask

   initial begin
      exp_t e;
      // Reset with run/pause held, then release: no event until re-pressed.
      cyc(1, 0, 4'b0001, 0, 8'd0, 0, "reset",        8'd0,   0, IDLE,  0);
      cyc(0, 0, 4'b0001, 0, 8'd0, 0, "held_rel",     8'd0,   0, IDLE,  0);
      cyc(0, 0, 4'b0001, 0, 8'd0, 0, "held2",        8'd0,   0, IDLE,  0);
      cyc(0, 0, 4'b0000, 0, 8'd0, 0, "released",     8'd0,   0, IDLE,  0);
      cyc(0, 0, 4'b0001, 0, 8'd0, 0, "press_run",    8'd0,   0, RUN,   0);
      cyc(0, 0, 4'b0000, 0, 8'd0, 0, "run_idle",     8'd0,   0, RUN,   0);
      // Saturate at 255.
      cyc(0, 0, 4'b0010, 0, 8'd0,   0, "up_ev",      8'd0,   0, RUN,   0);
      cyc(0, 0, 4'b1000, 0, 8'd253, 0, "load253",    8'd253, 0, PAUSE, 0);
      cyc(0, 0, 4'b0000, 0, 8'd0,   0, "after_ld",   8'd253, 0, PAUSE, 0);
      cyc(0, 0, 4'b0001, 0, 8'd0,   0, "resume",     8'd253, 0, RUN,   0);
      cyc(0, 0, 4'b0000, 1, 8'd0,   0, "tick254",    8'd254, 0, RUN,   0);
      cyc(0, 0, 4'b0000, 1, 8'd0,   0, "tick255",    8'd255, 0, RUN,   0);
      cyc(0, 0, 4'b0000, 1, 8'd0,   0, "sat_hold",   8'd255, 0, HOLD,  1);
      cyc(0, 0, 4'b0000, 1, 8'd0,   0, "hold_tick",  8'd255, 0, HOLD,  0);
      // HOLD release only when direction points away.
      cyc(0, 0, 4'b0001, 0, 8'd0,   0, "hold_run",   8'd255, 0, HOLD,  0);
      cyc(0, 0, 4'b0000, 0, 8'd0,   0, "hold_idle",  8'd255, 0, HOLD,  0);
      cyc(0, 0, 4'b0100, 0, 8'd0,   0, "down_ev",    8'd255, 1, HOLD,  0);
      cyc(0, 0, 4'b0000, 0, 8'd0,   0, "down_rel",   8'd255, 1, HOLD,  0);
      cyc(0, 0, 4'b0001, 0, 8'd0,   0, "hold_exit",  8'd255, 1, RUN,   0);
      cyc(0, 0, 4'b0000, 1, 8'd0,   0, "tick_dn",    8'd254, 1, RUN,   0);
      // Wrap down through 0.
      cyc(0, 1, 4'b1000, 0, 8'd0,   0, "load0",      8'd0,   1, PAUSE, 0);
      cyc(0, 1, 4'b0000, 0, 8'd0,   0, "ld0_rel",    8'd0,   1, PAUSE, 0);
      cyc(0, 1, 4'b0001, 0, 8'd0,   0, "run0",       8'd0,   1, RUN,   0);
      cyc(0, 1, 4'b0000, 1, 8'd0,   0, "wrap_dn",    8'd255, 1, RUN,   1);
      cyc(0, 1, 4'b0000, 0, 8'd0,   0, "wrap_pulse", 8'd255, 1, RUN,   0);
      cyc(0, 1, 4'b0000, 1, 8'd0,   0, "tick_254",   8'd254, 1, RUN,   0);
      // Up+down together with a step; run/pause together with a step.
      cyc(0, 0, 4'b1000, 0, 8'd10,  0, "load10",     8'd10,  1, PAUSE, 0);
      cyc(0, 0, 4'b0000, 0, 8'd0,   0, "ld10_rel",   8'd10,  1, PAUSE, 0);
      cyc(0, 0, 4'b0010, 0, 8'd0,   0, "up_p",       8'd10,  0, PAUSE, 0);
      cyc(0, 0, 4'b0000, 0, 8'd0,   0, "up_rel",     8'd10,  0, PAUSE, 0);
      cyc(0, 0, 4'b0001, 0, 8'd0,   0, "run10",      8'd10,  0, RUN,   0);
      cyc(0, 0, 4'b0110, 1, 8'd0,   0, "updn_tick",  8'd11,  0, RUN,   0);
      cyc(0, 0, 4'b0000, 0, 8'd0,   0, "updn_rel",   8'd11,  0, RUN,   0);
      cyc(0, 0, 4'b0001, 1, 8'd0,   0, "pause_step", 8'd12,  0, PAUSE, 0);
      cyc(0, 0, 4'b0000, 1, 8'd0,   0, "pause_tick", 8'd12,  0, PAUSE, 0);
      cyc(0, 0, 4'b0001, 0, 8'd0,   0, "rerun",      8'd12,  0, RUN,   0);
      cyc(0, 0, 4'b0000, 1, 8'd0,   0, "tick13",     8'd13,  0, RUN,   0);

      // Asynchronous reset between clock edges.
      @(negedge clk);
      #1;
      rst = 1'b1; btn = 4'b0000; tick = 1'b0;
      #2;
      e.sel = 0; e.name = "async_rst"; e.cnt = 8'd0; e.dir = 1'b0; e.st = IDLE; e.bnd = 1'b0;
      check(e);
      cyc(1, 1, 4'b0000, 0, 8'd0,   0, "rst_held",   8'd0,   0, IDLE,  0);

      // MAX_COUNT=99 instance: clamp, load priority, wrap at 99.
      cyc(0, 1, 4'b0000, 0, 8'd0,   1, "m99_idle",   8'd0,   0, IDLE,  0);
      cyc(0, 1, 4'b1000, 0, 8'd200, 1, "m99_clamp",  8'd99,  0, PAUSE, 0);
      cyc(0, 1, 4'b0000, 0, 8'd0,   1, "m99_rel",    8'd99,  0, PAUSE, 0);
      cyc(0, 1, 4'b0001, 0, 8'd0,   1, "m99_run",    8'd99,  0, RUN,   0);
      cyc(0, 1, 4'b0000, 0, 8'd0,   1, "m99_rel2",   8'd99,  0, RUN,   0);
      cyc(0, 1, 4'b1001, 1, 8'd50,  1, "m99_ldwin",  8'd50,  0, PAUSE, 0);
      cyc(0, 1, 4'b0000, 0, 8'd0,   1, "m99_rel3",   8'd50,  0, PAUSE, 0);
      cyc(0, 1, 4'b1000, 0, 8'd99,  1, "m99_ld99",   8'd99,  0, PAUSE, 0);
      cyc(0, 1, 4'b0000, 0, 8'd0,   1, "m99_rel4",   8'd99,  0, PAUSE, 0);
      cyc(0, 1, 4'b0001, 0, 8'd0,   1, "m99_run2",   8'd99,  0, RUN,   0);
      cyc(0, 1, 4'b0000, 1, 8'd0,   1, "m99_wrap",   8'd0,   0, RUN,   1);
      cyc(0, 1, 4'b0000, 1, 8'd0,   1, "m99_tick1",  8'd1,   0, RUN,   0);

      // Drain the scoreboard with a bounded wait.
      repeat (3) @(negedge clk);
      if (q.size() != 0) begin
         bad++;
         total++;
         $display("FAIL drain: %0d snapshots left, want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
